fetch_unit: RTL and testbench

//  Instruction fetch stage for the rv32i core. Owns the PC and issues in-order

---
 rtl/rv32_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32i field positions and the fetch buffer entry type.
package rv32_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int FUNC3_LSB  = 12;
  localparam int FUNC3_W    = 3;
  localparam int FUNC7_LSB  = 25;
  localparam int FUNC7_W    = 7;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide even when full.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// rv32i fetch stage: PC, credit-limited imem requests, instruction buffer, redirect.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_fault and stalls on misaligned redirects.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC3_W-1:0] func3,
  output logic [FUNC7_W-1:0] func7
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               misalign_fault
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc, rsp_pc, target;
  logic [CW-1:0]   outstanding, drop, out_next, fifo_count;
  logic            accept, rsp_drop, fifo_push, pop, credit;
  logic            fifo_full, fifo_empty, halted, misaligned;
  fetch_entry_t    head, push_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = redirect_pc[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_fault <= 1'b0;
      halted         <= 1'b0;
    end else begin
      misalign_fault <= redirect_valid && misaligned;
      if (redirect_valid) halted <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign halted     = 1'b0;
`endif

  assign target = redirect_pc & ~32'h3;

  // in-flight requests plus buffered words never exceed the buffer size
  assign credit         = (outstanding + fifo_count) < CW'(FIFO_DEPTH);
  assign imem_req_valid = !reset && !halted && credit;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop   = (drop != '0);
  assign fifo_push  = imem_rsp_valid && !rsp_drop && !redirect_valid && (!fifo_full || pop);
  assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};
  assign out_next   = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  assign instr_valid = !reset && !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc    : '0;
  assign opcode      = instr[OPCODE_LSB +: OPCODE_W];
  assign func3       = instr[FUNC3_LSB  +: FUNC3_W];
  assign func7       = instr[FUNC7_LSB  +: FUNC7_W];

  // rsp_pc tracks the address of the next non-dropped response, in order
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        drop <= out_next;
        if (!misaligned) begin
          pc     <= target;
          rsp_pc <= target;
        end
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (imem_rsp_valid) begin
          if (rsp_drop) drop   <= drop - CW'(1);
          else          rsp_pc <= rsp_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model (holdable responses).
module tb_fetch_unit;
  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_fault;
`endif

  int checks = 0;
  int errors = 0;
  logic        hold = 0;
  logic [31:0] pend[$];
  logic [31:0] reqs[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_w[$];

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_fault (misalign_fault)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hFE00_5013;
  endfunction

  // imem model and decode-side monitor: sample at the edge, drive responses 1 time unit later
  always @(posedge clk) begin
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready && !reset;
    a   = imem_req_addr;
    if (!reset && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_w.push_back(instr);
    end
    if (acc) reqs.push_back(a);
    #1;
    if (reset) pend.delete();
    else if (acc) pend.push_back(a);
    if (!hold && !reset && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1; redirect_valid = 0; redirect_pc = 0;
    imem_req_ready = 1; instr_ready = 1;
    cyc(2);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_req_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    checks++; if ({opcode, func3, func7} !== 17'h0) begin errors++; $display("FAIL rst_fields got %h want 0", {opcode, func3, func7}); end
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", misalign_fault); end
`endif
  endtask

  task automatic test_stream;
    got_pc.delete(); got_w.delete(); reqs.delete();
    reset = 0;
    cyc(20);
    checks++; if (got_pc.size() < 5) begin errors++; $display("FAIL stream_count got %0d want >=5", got_pc.size()); end
    for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, got_pc[i], i * 4); end
      checks++; if (got_w[i] !== word(32'(i * 4))) begin errors++; $display("FAIL stream_word[%0d] got %h want %h", i, got_w[i], word(32'(i * 4))); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    reset = 1; cyc(1);
    got_pc.delete(); got_w.delete(); reqs.delete();
    instr_ready = 0;
    reset = 0;
    cyc(10);
    checks++; if (reqs.size() != 2) begin errors++; $display("FAIL bp_req_count got %0d want 2", reqs.size()); end
    if (reqs.size() >= 2) begin
      checks++; if (reqs[0] !== 32'h0 || reqs[1] !== 32'h4) begin errors++; $display("FAIL bp_req_addrs got %h,%h want 0,4", reqs[0], reqs[1]); end
    end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
    checks++; if (instr !== 32'hFE00_5013) begin errors++; $display("FAIL bp_instr got %h want fe005013", instr); end
    checks++; if (opcode !== 7'h13 || func3 !== 3'h5 || func7 !== 7'h7F) begin errors++; $display("FAIL bp_fields got %h/%h/%h want 13/5/7f", opcode, func3, func7); end
    // responses held from here so the next two fetches stay in flight
    hold = 1; instr_ready = 1;
    n = 0;
    while (reqs.size() < 3 && n < 20) begin cyc(1); n++; end
    checks++; if (reqs.size() < 3 || reqs[2] !== 32'h8) begin errors++; $display("FAIL bp_resume got size %0d want third addr 8", reqs.size()); end
  endtask

  task automatic test_redirect_inflight;
    int n, base;
    n = 0;
    while (reqs.size() < 4 && n < 20) begin cyc(1); n++; end
    checks++; if (reqs.size() < 4 || reqs[3] !== 32'hC) begin errors++; $display("FAIL rd_inflight got size %0d want 4 with addr c", reqs.size()); end
    cyc(1);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_credit got %b want 0", imem_req_valid); end
    redirect_valid = 1; redirect_pc = 32'h100;
    cyc(1);
    redirect_valid = 0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_flush got %b want 0", instr_valid); end
    base = got_pc.size();
    hold = 0;
    n = 0;
    while (got_pc.size() < base + 2 && n < 30) begin cyc(1); n++; end
    checks++;
    if (got_pc.size() < base + 2) begin errors++; $display("FAIL rd_timeout got %0d entries want %0d", got_pc.size(), base + 2); end
    else if (got_pc[base] !== 32'h100 || got_pc[base+1] !== 32'h104 || got_w[base] !== word(32'h100))
      begin errors++; $display("FAIL rd_target got %h,%h want 100,104", got_pc[base], got_pc[base+1]); end
  endtask

  task automatic test_redirect_collide;
    int n, base;
    n = 0;
    while (!(imem_req_valid && imem_req_ready && imem_rsp_valid) && n < 20) begin cyc(1); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL col_find got none want accept+response cycle"); end
    redirect_valid = 1; redirect_pc = 32'h200;
    cyc(1);
    redirect_valid = 0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL col_flush got %b want 0", instr_valid); end
    base = got_pc.size();
    n = 0;
    while (got_pc.size() < base + 2 && n < 30) begin cyc(1); n++; end
    checks++;
    if (got_pc.size() < base + 2) begin errors++; $display("FAIL col_timeout got %0d entries want %0d", got_pc.size(), base + 2); end
    else if (got_pc[base] !== 32'h200 || got_pc[base+1] !== 32'h204 || got_w[base] !== word(32'h200))
      begin errors++; $display("FAIL col_target got %h,%h want 200,204", got_pc[base], got_pc[base+1]); end
  endtask

  task automatic test_stall_and_reset;
    int n;
    logic [31:0] a0;
    imem_req_ready = 0;
    n = 0;
    while (!imem_req_valid && n < 10) begin cyc(1); n++; end
    a0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) begin errors++; $display("FAIL stall[%0d] got v=%b addr=%h want v=1 addr=%h", i, imem_req_valid, imem_req_addr, a0); end
    end
    imem_req_ready = 1;
    cyc(3);
    reset = 1;
    cyc(1);
    checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got iv=%b rv=%b want 0,0", instr_valid, imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL mrst_addr got %h want 0", imem_req_addr); end
    got_pc.delete(); got_w.delete(); reqs.delete();
    reset = 0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL mrst_restart got v=%b addr=%h want v=1 addr=0", imem_req_valid, imem_req_addr); end
    cyc(6);
    checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h0) begin errors++; $display("FAIL mrst_first got %0d entries want first pc 0", got_pc.size()); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign;
    int n, r0, base;
    redirect_valid = 1; redirect_pc = 32'h102;
    cyc(1);
    redirect_valid = 0;
    checks++; if (misalign_fault !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b want 1", misalign_fault); end
    r0 = reqs.size();
    cyc(1);
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b want 0", misalign_fault); end
    cyc(6);
    checks++; if (reqs.size() != r0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_stall got %0d new reqs v=%b want 0 v=0", reqs.size() - r0, imem_req_valid); end
    redirect_valid = 1; redirect_pc = 32'h40;
    cyc(1);
    redirect_valid = 0;
    base = got_pc.size();
    n = 0;
    while (got_pc.size() < base + 1 && n < 30) begin cyc(1); n++; end
    checks++; if (got_pc.size() < base + 1 || got_pc[base] !== 32'h40) begin errors++; $display("FAIL mis_resume got %0d entries want first pc 40", got_pc.size() - base); end
  endtask
`endif

  initial begin
    imem_rsp_valid = 0; imem_rsp_data = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_stall_and_reset();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
